// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: the NOP encoding, the
// default boot PC, the fetch FSM state encoding and a PC increment helper.
package fetch_stage_pkg;

    localparam logic [6:0]  OPC_OP_IMM = 7'b001_0011;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_C = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};
    localparam logic [31:0] RESET_PC_C = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus.
// Handshake: a request transfers on a cycle where req & gnt are both high;
// addr may change while req is high but gnt is low. The single response
// arrives no earlier than one cycle after the grant, marked by rvalid with
// the word on rdata. The fetcher never has more than one request in flight.
interface fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register. Flush and bubble both empty it to a NOP; load
// captures a new instruction; otherwise the contents hold (stall).
module fetch_stage_if_id
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_C,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        valid_q;

    // Flush beats load, load beats bubble; no control means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc_q    <= pc_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end else if (bubble_i) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: keeps the PC, issues one fetch at a time over the
// req/gnt/rvalid bus, parks a returned word in a one-entry skid buffer when
// decode is stalled, and drops in-flight words made stale by a redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_C,
    parameter logic [31:0] NOP_INST = NOP_INST_C
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_delay,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic [31:0]   id_pc,
    output logic [31:0]   id_inst,
    output logic          id_valid,
    output fetch_state_e  dbg_state,
    output logic          dbg_kill
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_pc_q;   // address of the request currently in flight
    logic         kill_q;       // in-flight word is stale, drop it on return
    logic         req_q;
    logic         skid_valid_q;
    logic [31:0]  skid_pc_q;
    logic [31:0]  skid_inst_q;

    logic         can_load;
    logic         word_live;
    logic         new_word;
    logic         id_load;
    logic         id_bubble;
    logic [31:0]  id_pc_d;
    logic [31:0]  id_inst_d;

    // Decode takes a new entry when empty, or when it consumes the current one.
    assign can_load  = !id_valid || !pc_delay;
    assign word_live = (state_q == ST_WAIT) && imem.rvalid && !kill_q;

    // IF/ID advance control: load a fresh or parked word, else insert a bubble.
    always_comb begin
        new_word  = word_live || ((state_q == ST_HOLD) && skid_valid_q);
        id_load   = can_load && new_word;
        id_bubble = can_load && !new_word;
        id_pc_d   = fetch_pc_q;
        id_inst_d = imem.rdata;
        if (state_q == ST_HOLD) begin
            id_pc_d   = skid_pc_q;
            id_inst_d = skid_inst_q;
        end
    end

    // Fetch FSM with PC, kill flag, skid buffer and registered request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            req_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= RESET_PC;
            skid_inst_q  <= NOP_INST;
        end else if (redirect_valid) begin
            // A redirect always wins; only an outstanding request keeps us in WAIT.
            pc_q         <= redirect_pc;
            skid_valid_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        kill_q  <= 1'b0;
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end else begin
                        kill_q  <= 1'b1;
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (imem.gnt) begin
                        kill_q  <= 1'b1;
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end else begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    kill_q  <= 1'b0;
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem.gnt) begin
                        fetch_pc_q <= pc_q;
                        pc_q       <= pc_inc(pc_q);
                        state_q    <= ST_WAIT;
                        req_q      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end else if (can_load) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            skid_valid_q <= 1'b1;
                            skid_pc_q    <= fetch_pc_q;
                            skid_inst_q  <= imem.rdata;
                            state_q      <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (can_load) begin
                        skid_valid_q <= 1'b0;
                        state_q      <= ST_REQ;
                        req_q        <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem.req  = req_q;
    assign imem.addr = pc_q;
    assign dbg_state = state_q;
    assign dbg_kill  = kill_q;

    fetch_stage_if_id #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (redirect_valid),
        .load_i   (id_load),
        .bubble_i (id_bubble),
        .pc_i     (id_pc_d),
        .inst_i   (id_inst_d),
        .pc_o     (id_pc),
        .inst_o   (id_inst),
        .valid_o  (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table covering boot,
// stall/skid, memory back-pressure and redirects, then a hand-written
// asynchronous reset in the middle of an outstanding fetch.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 21;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pc_delay;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [31:0]  id_pc;
    logic [31:0]  id_inst;
    logic         id_valid;
    fetch_state_e dbg_state;
    logic         dbg_kill;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_delay       (pc_delay),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_valid       (id_valid),
        .dbg_state      (dbg_state),
        .dbg_kill       (dbg_kill)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector record ----------------
    typedef struct packed {
        logic         dly;
        logic         rv;
        logic [31:0]  rpc;
        logic         gnt;
        logic         rvalid;
        logic [31:0]  rdata;
        logic         e_req;
        logic [31:0]  e_addr;
        logic         e_valid;
        logic [31:0]  e_pc;
        logic [31:0]  e_inst;
        logic         e_kill;
        fetch_state_e e_state;
    } vec_t;

    vec_t tbl [NV];

    // Instruction word the bench's memory returns for address a.
    function automatic logic [31:0] w(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    function automatic vec_t vec(
        input logic dly, input logic rv, input logic [31:0] rpc,
        input logic gnt, input logic rvalid, input logic [31:0] rdata,
        input logic e_req, input logic [31:0] e_addr, input logic e_valid,
        input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_kill,
        input fetch_state_e e_state);
        vec_t v;
        v.dly = dly;  v.rv = rv;  v.rpc = rpc;  v.gnt = gnt;
        v.rvalid = rvalid;  v.rdata = rdata;
        v.e_req = e_req;  v.e_addr = e_addr;  v.e_valid = e_valid;
        v.e_pc = e_pc;  v.e_inst = e_inst;  v.e_kill = e_kill;  v.e_state = e_state;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic dly, input logic rv, input logic [31:0] rpc,
                         input logic gnt, input logic rvalid, input logic [31:0] rdata);
        pc_delay        = dly;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        imem_bus.gnt    = gnt;
        imem_bus.rvalid = rvalid;
        imem_bus.rdata  = rdata;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_pc,
                                 input logic [31:0] e_inst, input logic e_kill,
                                 input fetch_state_e e_state);
        chk({tag, " imem_req"},  {31'd0, imem_bus.req}, {31'd0, e_req});
        chk({tag, " imem_addr"}, imem_bus.addr, e_addr);
        chk({tag, " id_valid"},  {31'd0, id_valid}, {31'd0, e_valid});
        chk({tag, " id_inst"},   id_inst, e_inst);
        if (e_valid) chk({tag, " id_pc"}, id_pc, e_pc);
        chk({tag, " kill"},      {31'd0, dbg_kill}, {31'd0, e_kill});
        chk({tag, " state"},     {30'd0, dbg_state}, {30'd0, e_state});
    endtask

    task automatic check_reset(input string tag);
        check_outputs(tag, 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, ST_BOOT);
        chk({tag, " id_pc"}, id_pc, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);

        //            dly rv rpc          gnt rvl rdata          req addr         vld pc      inst          kill state
        // boot and steady fetch of 0x0, 0x4
        tbl[0]  = vec(0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h000, 0, 32'h0,   NOP,          0, ST_BOOT);
        tbl[1]  = vec(0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h000, 0, 32'h0,   NOP,          0, ST_REQ);
        tbl[2]  = vec(0, 0, 32'h0,   1, 1, w(32'h0),    0, 32'h004, 0, 32'h0,   NOP,          0, ST_WAIT);
        tbl[3]  = vec(0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h004, 1, 32'h0,   w(32'h0),     0, ST_REQ);
        tbl[4]  = vec(0, 0, 32'h0,   1, 1, w(32'h4),    0, 32'h008, 0, 32'h0,   NOP,          0, ST_WAIT);
        // load-use stall for two cycles: 0x8 parks in the skid buffer
        tbl[5]  = vec(1, 0, 32'h0,   1, 0, 32'h0,       1, 32'h008, 1, 32'h4,   w(32'h4),     0, ST_REQ);
        tbl[6]  = vec(1, 0, 32'h0,   1, 1, w(32'h8),    0, 32'h00C, 1, 32'h4,   w(32'h4),     0, ST_WAIT);
        tbl[7]  = vec(0, 0, 32'h0,   1, 0, 32'h0,       0, 32'h00C, 1, 32'h4,   w(32'h4),     0, ST_HOLD);
        // memory back-pressure at 0xC, then redirect while ungranted
        tbl[8]  = vec(0, 0, 32'h0,   0, 0, 32'h0,       1, 32'h00C, 1, 32'h8,   w(32'h8),     0, ST_REQ);
        tbl[9]  = vec(0, 0, 32'h0,   0, 0, 32'h0,       1, 32'h00C, 0, 32'h0,   NOP,          0, ST_REQ);
        tbl[10] = vec(0, 1, 32'h200, 0, 0, 32'h0,       1, 32'h00C, 0, 32'h0,   NOP,          0, ST_REQ);
        tbl[11] = vec(0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h200, 0, 32'h0,   NOP,          0, ST_REQ);
        // redirect in WAIT before the word returns: word is killed
        tbl[12] = vec(0, 1, 32'h100, 0, 0, 32'h0,       0, 32'h204, 0, 32'h0,   NOP,          0, ST_WAIT);
        tbl[13] = vec(1, 0, 32'h0,   0, 1, w(32'h200),  0, 32'h100, 0, 32'h0,   NOP,          1, ST_WAIT);
        tbl[14] = vec(0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h100, 0, 32'h0,   NOP,          0, ST_REQ);
        tbl[15] = vec(0, 0, 32'h0,   1, 1, w(32'h100),  0, 32'h104, 0, 32'h0,   NOP,          0, ST_WAIT);
        // redirect with rvalid and pc_delay in the same cycle
        tbl[16] = vec(1, 0, 32'h0,   1, 0, 32'h0,       1, 32'h104, 1, 32'h100, w(32'h100),   0, ST_REQ);
        tbl[17] = vec(1, 1, 32'h300, 0, 1, w(32'h104),  0, 32'h108, 1, 32'h100, w(32'h100),   0, ST_WAIT);
        // redirect in the same cycle as a grant
        tbl[18] = vec(0, 1, 32'h400, 1, 0, 32'h0,       1, 32'h300, 0, 32'h0,   NOP,          0, ST_REQ);
        tbl[19] = vec(0, 0, 32'h0,   0, 1, w(32'h300),  0, 32'h400, 0, 32'h0,   NOP,          1, ST_WAIT);
        tbl[20] = vec(0, 0, 32'h0,   1, 0, 32'h0,       1, 32'h400, 0, 32'h0,   NOP,          0, ST_REQ);

        repeat (3) @(negedge clk);
        check_reset("reset");

        // Release at a negedge so row 0 observes the BOOT cycle.
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            check_outputs($sformatf("c%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                          tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_kill, tbl[i].e_state);
            drive(tbl[i].dly, tbl[i].rv, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata);
            @(negedge clk);
        end

        // Asynchronous reset while a fetch to 0x400 is outstanding.
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check_outputs("pre-rst", 1'b0, 32'h404, 1'b0, 32'h0, NOP, 1'b0, ST_WAIT);
        #2 rst_n = 1'b0;
        #1 check_reset("async-rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 1, w(32'h400));   // late response for the aborted fetch
        check_outputs("post-rst c0", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0, ST_BOOT);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        check_outputs("post-rst c1", 1'b1, 32'h0, 1'b0, 32'h0, NOP, 1'b0, ST_REQ);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1, w(32'h0));
        check_outputs("post-rst c2", 1'b0, 32'h4, 1'b0, 32'h0, NOP, 1'b0, ST_WAIT);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        check_outputs("post-rst c3", 1'b1, 32'h4, 1'b1, 32'h0, w(32'h0), 1'b0, ST_REQ);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
